// File: rtl/tick_sched_pkg.sv
// Shared types and helpers for the tick scheduler.
package tick_sched_pkg;

  // Command opcodes on cmd_op.
  typedef enum logic [1:0] {
    OP_LOAD    = 2'b00,
    OP_START   = 2'b01,
    OP_STOP    = 2'b10,
    OP_ACK_OVR = 2'b11
  } op_e;

  // Channel-index width; a single channel still needs one bit.
  function automatic int ch_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Decoded view of the command port for the current cycle.
  typedef struct packed {
    logic acc;    // valid & ready
    logic ch_ok;  // cmd_ch addresses an existing channel
    op_e  op;
  } cmd_dec_t;

  // Per-channel event strobes for the current cycle.
  typedef struct packed {
    logic expire; // tick took cnt from 1 to expiry
    logic pop;    // consumer takes this channel's event
  } ch_evt_t;

endpackage

// File: rtl/tick_prescaler.sv
// Shared timebase: one-cycle tick every CLK_HZ/TICK_HZ clocks.
module tick_prescaler #(
  parameter  int CLK_HZ  = 100_000_000,
  parameter  int TICK_HZ = 10,
  localparam int DIV     = CLK_HZ / TICK_HZ,
  localparam int PC_W    = (DIV < 2) ? 1 : $clog2(DIV)
) (
  input  logic clk_100MHz,
  input  logic rst_n,
  output logic tick
);

  logic [PC_W-1:0] pc;

  // Tick is decoded from the terminal count, so it is low while pc is held at 0 in reset.
  assign tick = (pc == PC_W'(DIV - 1));

  // Free-running 0..DIV-1 counter.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n)    pc <= '0;
    else if (tick) pc <= '0;
    else           pc <= pc + PC_W'(1);
  end

endmodule

// File: rtl/tick_sched.sv
// Shared-timebase scheduler: N_CH down-count timers on one prescaled tick,
// programmed through a valid/ready command port; expirations are queued as
// pending flags and issued one at a time on a round-robin event port.
module tick_sched
  import tick_sched_pkg::*;
#(
  parameter  int CLK_HZ  = 100_000_000,
  parameter  int TICK_HZ = 10,
  parameter  int N_CH    = 4,
  parameter  int CNT_W   = 16,
  localparam int CH_W    = ch_w(N_CH)
) (
  input  logic             clk_100MHz,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CH_W-1:0]  cmd_ch,
  input  logic [CNT_W-1:0] cmd_data,
  output logic             cmd_err,
  output logic             tick,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CH_W-1:0]  evt_ch,
  output logic [N_CH-1:0]  running,
  output logic [N_CH-1:0]  overrun
);

  cmd_dec_t        cmd;
  logic            ch_ok;
  logic [N_CH-1:0] hit;
  logic [N_CH-1:0] zero_start;
  logic [N_CH-1:0] pending;
  logic [CH_W-1:0] ptr;
  logic [CH_W-1:0] next_ptr;
  logic [CH_W-1:0] gnt_ch;
  logic            gnt_any;

  tick_prescaler #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_pre (
    .clk_100MHz (clk_100MHz),
    .rst_n      (rst_n),
    .tick       (tick)
  );

  // Out-of-range channel numbers only exist when N_CH is not a power of two.
  if (N_CH == (1 << CH_W)) begin : g_ch_pow2
    assign ch_ok = 1'b1;
  end else begin : g_ch_npow2
    assign ch_ok = (32'(cmd_ch) < N_CH);
  end

  assign cmd = '{acc: cmd_valid & cmd_ready, ch_ok: ch_ok, op: op_e'(cmd_op)};

  // Ready comes up on the first clock after reset release and stays up.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) cmd_ready <= 1'b0;
    else        cmd_ready <= 1'b1;
  end

  // Reject pulse: bad channel, or START on a channel with no period loaded.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) cmd_err <= 1'b0;
    else        cmd_err <= (cmd.acc & ~cmd.ch_ok) | (|zero_start);
  end

  // Channel array: a command to a channel wins over that channel's tick.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] cnt_q;
    logic             run_q;
    logic             per_q;
    logic             pend_q;
    logic             ovr_q;
    ch_evt_t          ev;

    assign hit[i]        = cmd.acc & cmd.ch_ok & (cmd_ch == CH_W'(i));
    assign zero_start[i] = hit[i] & (cmd.op == OP_START) & (period_q == '0);
    assign ev = '{
      expire: tick & run_q & ~hit[i] & (cnt_q == CNT_W'(1)),
      pop:    evt_valid & evt_ready & (evt_ch == CH_W'(i))
    };

    assign running[i] = run_q;
    assign overrun[i] = ovr_q;
    assign pending[i] = pend_q;

    // Timer state, pending flag and sticky overrun for one channel.
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
      if (!rst_n) begin
        period_q <= '0;
        cnt_q    <= '0;
        run_q    <= 1'b0;
        per_q    <= 1'b0;
        pend_q   <= 1'b0;
        ovr_q    <= 1'b0;
      end else begin
        if (hit[i]) begin
          case (cmd.op)
            OP_LOAD: begin
              period_q <= cmd_data;
              cnt_q    <= cmd_data;
            end
            OP_START: begin
              if (period_q != '0) begin
                run_q <= 1'b1;
                per_q <= cmd_data[0];
                cnt_q <= period_q;
              end
            end
            OP_STOP:    run_q <= 1'b0;
            OP_ACK_OVR: ovr_q <= 1'b0;
          endcase
        end else if (tick && run_q) begin
          // cnt==0 while running (LOAD 0 mid-run) just parks; never wraps.
          if (cnt_q > CNT_W'(1)) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (ev.expire) begin
            if (per_q) begin
              cnt_q <= period_q;
            end else begin
              cnt_q <= '0;
              run_q <= 1'b0;
            end
          end
        end
        // An expiry landing on a pop re-arms pending without flagging overrun.
        if (ev.expire) begin
          if (pend_q && !ev.pop) ovr_q <= 1'b1;
          pend_q <= 1'b1;
        end else if (ev.pop) begin
          pend_q <= 1'b0;
        end
      end
    end
  end

  // Round-robin pick: first pending channel at or after ptr. Scanning from the
  // far end lets the nearest match overwrite the others.
  always_comb begin
    int idx;
    gnt_any = 1'b0;
    gnt_ch  = '0;
    idx     = 0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (pending[idx]) begin
        gnt_any = 1'b1;
        gnt_ch  = CH_W'(idx);
      end
    end
  end

  assign next_ptr = (evt_ch == CH_W'(N_CH - 1)) ? '0 : evt_ch + CH_W'(1);

  // Event port: hold the grant until taken, then idle one cycle before the next.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      ptr       <= '0;
    end else if (evt_valid) begin
      if (evt_ready) begin
        evt_valid <= 1'b0;
        ptr       <= next_ptr;
      end
    end else if (gnt_any) begin
      evt_valid <= 1'b1;
      evt_ch    <= gnt_ch;
    end
  end

endmodule

// File: tb/tb_tick_sched.sv
// Directed bench for tick_sched: DIV=10, 4 channels, 8-bit counters, plus a
// 5-channel instance for out-of-range channel numbers.
module tb_tick_sched;

  localparam logic [1:0] LOAD = 2'b00, START = 2'b01, STOP = 2'b10, ACK = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_err, tick;
  logic [1:0] cmd_op = '0, cmd_ch = '0;
  logic [7:0] cmd_data = '0;
  logic       evt_valid, evt_ready = 1'b0;
  logic [1:0] evt_ch;
  logic [3:0] running, overrun;

  logic       c2_valid = 1'b0, c2_ready, c2_err, c2_tick, c2_evt_valid;
  logic [1:0] c2_op = '0;
  logic [2:0] c2_ch = '0, c2_evt_ch;
  logic [7:0] c2_data = '0;
  logic [4:0] c2_running, c2_overrun;

  int passed = 0, total = 0;

  always #5 clk = ~clk;

  tick_sched #(.CLK_HZ(100), .TICK_HZ(10), .N_CH(4), .CNT_W(8)) dut (
    .clk_100MHz(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_data(cmd_data), .cmd_err(cmd_err),
    .tick(tick), .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ch(evt_ch),
    .running(running), .overrun(overrun)
  );

  tick_sched #(.CLK_HZ(100), .TICK_HZ(10), .N_CH(5), .CNT_W(8)) dut5 (
    .clk_100MHz(clk), .rst_n(rst_n), .cmd_valid(c2_valid), .cmd_ready(c2_ready),
    .cmd_op(c2_op), .cmd_ch(c2_ch), .cmd_data(c2_data), .cmd_err(c2_err),
    .tick(c2_tick), .evt_valid(c2_evt_valid), .evt_ready(1'b0), .evt_ch(c2_evt_ch),
    .running(c2_running), .overrun(c2_overrun)
  );

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Returns one sample after the accepting edge, where cmd_err is visible.
  task automatic send(input logic [1:0] op, input logic [1:0] ch, input logic [7:0] data);
    cmd_valid = 1'b1; cmd_op = op; cmd_ch = ch; cmd_data = data;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send2(input logic [1:0] op, input logic [2:0] ch, input logic [7:0] data);
    c2_valid = 1'b1; c2_op = op; c2_ch = ch; c2_data = data;
    @(posedge clk); #1;
    c2_valid = 1'b0;
  endtask

  // Stops inside a tick cycle; the next edge is the tick edge.
  task automatic wait_tick();
    int n;
    n = 0;
    while (tick !== 1'b1 && n < 25) begin @(posedge clk); #1; n++; end
    total++; if (tick !== 1'b1) $display("FAIL tick_timeout tick=%b after %0d cycles", tick, n); else passed++;
  endtask

  task automatic test_reset();
    step(3);
    total++; if (cmd_ready !== 1'b0) $display("FAIL rst_ready got=%b exp=0", cmd_ready); else passed++;
    total++; if ({tick, evt_valid, cmd_err, evt_ch, running, overrun} !== 13'd0)
      $display("FAIL rst_outputs got=%b exp=0", {tick, evt_valid, cmd_err, evt_ch, running, overrun}); else passed++;
    rst_n = 1'b1;
    step(1);
    total++; if (cmd_ready !== 1'b1) $display("FAIL ready_after_rst got=%b exp=1", cmd_ready); else passed++;
    // pc equals k after the k-th edge; tick is high only while pc==9.
    for (int k = 1; k <= 20; k++) begin
      total++; if (tick !== ((k % 10) == 9)) $display("FAIL tick_phase k=%0d got=%b exp=%b", k, tick, (k % 10) == 9); else passed++;
      step(1);
    end
  endtask

  task automatic test_rr_order();
    logic [1:0] got[$];
    for (int c = 0; c < 4; c++) send(LOAD, 2'(c), 8'd1);
    wait_tick(); step(1);
    for (int c = 0; c < 4; c++) send(START, 2'(c), 8'd0);
    total++; if (running !== 4'hF) $display("FAIL rr_running got=%h exp=f", running); else passed++;
    evt_ready = 1'b1;
    wait_tick(); step(1);
    total++; if (running !== 4'h0) $display("FAIL rr_oneshot_stop got=%h exp=0", running); else passed++;
    for (int c = 0; c < 12; c++) begin
      step(1);
      if (evt_valid === 1'b1) got.push_back(evt_ch);
    end
    total++; if (got.size() != 4) $display("FAIL rr_count got=%0d exp=4", got.size()); else passed++;
    for (int c = 0; c < 4 && c < got.size(); c++) begin
      total++; if (got[c] !== 2'(c)) $display("FAIL rr_order idx=%0d got=%0d exp=%0d", c, got[c], c); else passed++;
    end
    // Pointer wrapped to 0: with ch3 and ch0 pending, ch0 must go first.
    evt_ready = 1'b0;
    wait_tick(); step(1);
    send(START, 2'd3, 8'd0);
    send(START, 2'd0, 8'd0);
    wait_tick(); step(2);
    total++; if (evt_valid !== 1'b1 || evt_ch !== 2'd0) $display("FAIL rr_wrap_first got=%b/%0d exp=1/0", evt_valid, evt_ch); else passed++;
    evt_ready = 1'b1;
    step(2);
    total++; if (evt_valid !== 1'b1 || evt_ch !== 2'd3) $display("FAIL rr_wrap_second got=%b/%0d exp=1/3", evt_valid, evt_ch); else passed++;
    step(1);
    evt_ready = 1'b0;
  endtask

  task automatic test_oneshot();
    send(LOAD, 2'd1, 8'd3);
    send(START, 2'd1, 8'd0);
    total++; if (running !== 4'b0010 || cmd_err !== 1'b0) $display("FAIL os_start got=%b/%b exp=0010/0", running, cmd_err); else passed++;
    wait_tick(); step(1);
    wait_tick(); step(1);
    total++; if (evt_valid !== 1'b0) $display("FAIL os_early got=%b exp=0", evt_valid); else passed++;
    wait_tick(); step(1);
    total++; if (running[1] !== 1'b0 || evt_valid !== 1'b0) $display("FAIL os_expire got=%b/%b exp=0/0", running[1], evt_valid); else passed++;
    step(1);
    total++; if (evt_valid !== 1'b1 || evt_ch !== 2'd1) $display("FAIL os_event got=%b/%0d exp=1/1", evt_valid, evt_ch); else passed++;
    evt_ready = 1'b1; step(1); evt_ready = 1'b0;
    total++; if (evt_valid !== 1'b0) $display("FAIL os_pop got=%b exp=0", evt_valid); else passed++;
  endtask

  task automatic test_overrun();
    send(LOAD, 2'd0, 8'd2);
    send(START, 2'd0, 8'd1);
    for (int t = 0; t < 5; t++) begin wait_tick(); step(1); end
    step(1);
    total++; if (evt_valid !== 1'b1 || evt_ch !== 2'd0) $display("FAIL ovr_held got=%b/%0d exp=1/0", evt_valid, evt_ch); else passed++;
    total++; if (overrun !== 4'b0001 || running[0] !== 1'b1) $display("FAIL ovr_flag got=%b/%b exp=0001/1", overrun, running[0]); else passed++;
    send(STOP, 2'd0, 8'd0);
    total++; if (running[0] !== 1'b0) $display("FAIL ovr_stop got=%b exp=0", running[0]); else passed++;
    send(ACK, 2'd0, 8'd0);
    total++; if (overrun !== 4'b0000 || cmd_err !== 1'b0) $display("FAIL ovr_ack got=%b/%b exp=0000/0", overrun, cmd_err); else passed++;
    evt_ready = 1'b1; step(1); evt_ready = 1'b0;
    step(2);
    total++; if (evt_valid !== 1'b0 || overrun !== 4'b0000) $display("FAIL ovr_drain got=%b/%b exp=0/0000", evt_valid, overrun); else passed++;
  endtask

  task automatic test_errors();
    send(LOAD, 2'd2, 8'd0);
    total++; if (cmd_err !== 1'b0) $display("FAIL err_load0 got=%b exp=0", cmd_err); else passed++;
    send(START, 2'd2, 8'd0);
    total++; if (cmd_err !== 1'b1 || running[2] !== 1'b0) $display("FAIL err_start0 got=%b/%b exp=1/0", cmd_err, running[2]); else passed++;
    step(1);
    total++; if (cmd_err !== 1'b0) $display("FAIL err_pulse got=%b exp=0", cmd_err); else passed++;
    send(LOAD, 2'd2, 8'd255);
    send(START, 2'd2, 8'd0);
    total++; if (cmd_err !== 1'b0 || running[2] !== 1'b1) $display("FAIL err_maxper got=%b/%b exp=0/1", cmd_err, running[2]); else passed++;
    send(STOP, 2'd2, 8'd0);
    send2(START, 3'd5, 8'd1);
    total++; if (c2_err !== 1'b1 || c2_running !== 5'd0) $display("FAIL err_badch got=%b/%b exp=1/00000", c2_err, c2_running); else passed++;
    send2(LOAD, 3'd4, 8'd5);
    send2(START, 3'd4, 8'd0);
    total++; if (c2_err !== 1'b0 || c2_running !== 5'b10000 || c2_ready !== 1'b1) $display("FAIL err_lastch got=%b/%b exp=0/10000", c2_err, c2_running); else passed++;
    total++; if (c2_evt_valid !== 1'b0 || c2_overrun !== 5'd0 || c2_evt_ch !== 3'd0) $display("FAIL dut5_idle got=%b/%b/%0d exp=0/0/0", c2_evt_valid, c2_overrun, c2_evt_ch); else passed++;
  endtask

  task automatic test_tick_collision();
    send(LOAD, 2'd3, 8'd3);
    send(START, 2'd3, 8'd0);
    wait_tick(); step(1);          // 3 -> 2
    wait_tick(); send(ACK, 2'd3, 8'd0); // command owns this tick: stays 2
    wait_tick(); step(1);          // 2 -> 1
    step(1);
    total++; if (evt_valid !== 1'b0) $display("FAIL coll_ack_lost got=%b exp=0", evt_valid); else passed++;
    wait_tick(); send(STOP, 2'd3, 8'd0); // would expire at cnt==1, but STOP wins
    total++; if (running[3] !== 1'b0) $display("FAIL coll_stop got=%b exp=0", running[3]); else passed++;
    step(2);
    total++; if (evt_valid !== 1'b0) $display("FAIL coll_no_expire got=%b exp=0", evt_valid); else passed++;
  endtask

  task automatic test_reset_mid();
    send(LOAD, 2'd1, 8'd1);
    send(START, 2'd1, 8'd0);
    send(LOAD, 2'd0, 8'd5);
    send(START, 2'd0, 8'd1);
    wait_tick(); step(2);
    total++; if (evt_valid !== 1'b1 || evt_ch !== 2'd1 || running[0] !== 1'b1) $display("FAIL mid_pre got=%b/%0d/%b exp=1/1/1", evt_valid, evt_ch, running[0]); else passed++;
    #3 rst_n = 1'b0;
    #1;
    total++; if ({cmd_ready, tick, evt_valid, cmd_err, evt_ch, running, overrun} !== 14'd0)
      $display("FAIL mid_reset got=%b exp=0", {cmd_ready, tick, evt_valid, cmd_err, evt_ch, running, overrun}); else passed++;
  endtask

  initial begin
    test_reset();
    test_rr_order();
    test_oneshot();
    test_overrun();
    test_errors();
    test_tick_collision();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
